// File: rtl/regfile_wb_queue.sv
// Writeback front end for the 32x32 register file: arbitrates two producers into
// an in-order queue that drains one write per cycle, with read-side bypass lookups.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [AW-1:0]            a_addr,
  input  logic [DW-1:0]            a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [AW-1:0]            b_addr,
  input  logic [DW-1:0]            b_data,
  output logic                     wb_en,
  output logic [AW-1:0]            wb_addr,
  output logic [DW-1:0]            wb_data,
  input  logic [AW-1:0]            rd1_addr,
  output logic                     rd1_hit,
  output logic [DW-1:0]            rd1_data,
  input  logic [AW-1:0]            rd2_addr,
  output logic                     rd2_hit,
  output logic [DW-1:0]            rd2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    entry_addr [DEPTH];
  logic [DW-1:0]    entry_data [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;

  logic            full;
  logic            a_xfer;
  logic            b_xfer;
  logic            enq;
  logic            deq;
  logic [AW-1:0]   enq_addr;
  logic [DW-1:0]   enq_data;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

  // Readiness depends only on the current occupancy, never on a same-cycle pop.
  assign a_ready = !rst && !full;
  assign b_ready = !rst && !full && !a_valid;

  assign a_xfer   = a_valid && a_ready;
  assign b_xfer   = b_valid && b_ready;
  assign enq_addr = a_xfer ? a_addr : b_addr;
  assign enq_data = a_xfer ? a_data : b_data;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign enq = (a_xfer || b_xfer) && (enq_addr != '0);
  assign deq = !empty;

  assign wb_en   = !empty;
  assign wb_addr = entry_addr[rd_ptr];
  assign wb_data = entry_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      entry_valid <= '0;
    end else begin
      if (deq) begin
        rd_ptr              <= rd_ptr + PW'(1);
        entry_valid[rd_ptr] <= 1'b0;
      end
      if (enq) begin
        wr_ptr              <= wr_ptr + PW'(1);
        entry_valid[wr_ptr] <= 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      entry_addr[wr_ptr] <= enq_addr;
      entry_data[wr_ptr] <= enq_data;
    end
  end

  // Walk slots oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    rd1_hit  = 1'b0;
    rd1_data = '0;
    rd2_hit  = 1'b0;
    rd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (entry_valid[idx]) begin
        if ((rd1_addr != '0) && (entry_addr[idx] == rd1_addr)) begin
          rd1_hit  = 1'b1;
          rd1_data = entry_data[idx];
        end
        if ((rd2_addr != '0) && (entry_addr[idx] == rd2_addr)) begin
          rd2_hit  = 1'b1;
          rd2_data = entry_data[idx];
        end
      end
    end
  end

endmodule
